// File: rtl/serializer_param.sv
// serializer_param: parallel-to-serial shifter with per-word length, 1-deep hold register and zero-gap frames.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each frame's data bits.
module serializer_param #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = $clog2(DATA_W + 1),
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_val_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic              busy_o
);
  localparam int CNT_W = $clog2(BIT_CYCLES + 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(BIT_CYCLES - 1);
`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t            r_state, w_state;
  logic [DATA_W-1:0] r_shift, w_shift, r_hold_data;
  logic [LEN_W-1:0]  r_hold_len;
  logic              r_hold_full, r_rdy_en;
  logic [LEN_W:0]    r_left, w_left;
  logic [CNT_W-1:0]  r_cyc, w_cyc;
  logic              r_ser_data, w_ser_data, r_ser_val, w_ser_val;
  logic              r_sof, w_sof, r_eof, w_eof;
  logic              w_accept, w_bit_end, w_frame_end, w_slot;
  logic              w_from_hold, w_from_in, w_load, w_hold_full;
  logic [LEN_W-1:0]  w_in_len, w_ld_len;
  logic [DATA_W-1:0] w_ld_data, w_aligned, w_adv_shift;
  logic              w_adv_bit;
  assign w_in_len   = (len_i == '0 || len_i > FULL_LEN) ? FULL_LEN : len_i;
  assign data_rdy_o = r_rdy_en && !r_hold_full;
  assign w_accept   = data_val_i && data_rdy_o;
  assign w_bit_end  = r_cyc == '0;
`ifdef SERIALIZER_PARITY_EN
  logic r_par;
  assign w_frame_end = (r_state == PARITY) && w_bit_end;
`else
  assign w_frame_end = (r_state == SHIFT) && w_bit_end && r_left == (LEN_W+1)'(1);
`endif
  // The shifter is free in IDLE or on the closing edge of a frame; hold has priority.
  assign w_slot      = (r_state == IDLE) || w_frame_end;
  assign w_from_hold = w_slot && r_hold_full;
  assign w_from_in   = w_slot && !r_hold_full && w_accept;
  assign w_load      = w_from_hold || w_from_in;
  assign w_hold_full = (w_accept && !w_from_in) || (r_hold_full && !w_from_hold);
  assign w_ld_data   = w_from_hold ? r_hold_data : data_i;
  assign w_ld_len    = w_from_hold ? r_hold_len : w_in_len;
  // Align the word so the first bit sits at the shift-out end and unused bits drop away.
  assign w_aligned   = MSB_FIRST ? w_ld_data << (FULL_LEN - w_ld_len)
                                 : w_ld_data & ({DATA_W{1'b1}} >> (FULL_LEN - w_ld_len));
  assign w_adv_bit   = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
  assign w_adv_shift = MSB_FIRST ? r_shift << 1 : r_shift >> 1;
  assign ser_data_o  = r_ser_data;
  assign ser_val_o   = r_ser_val;
  assign sof_o       = r_sof;
  assign eof_o       = r_eof;
  assign busy_o      = (r_state != IDLE) || r_hold_full;
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_left     = r_left;
    w_cyc      = r_cyc;
    w_ser_data = r_ser_data;
    w_ser_val  = r_ser_val;
    w_sof      = r_sof;
    w_eof      = r_eof;
    if (w_load) begin
      w_state    = SHIFT;
      w_shift    = MSB_FIRST ? w_aligned << 1 : w_aligned >> 1;
      w_ser_data = MSB_FIRST ? w_aligned[DATA_W-1] : w_aligned[0];
      w_ser_val  = 1'b1;
      w_sof      = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      w_eof      = 1'b0;
`else
      w_eof      = w_ld_len == LEN_W'(1);
`endif
      w_left     = {1'b0, w_ld_len};
      w_cyc      = CYC_LAST;
    end else if (w_frame_end) begin
      w_state    = IDLE;
      w_shift    = '0;
      w_left     = '0;
      w_cyc      = '0;
      w_ser_data = 1'b0;
      w_ser_val  = 1'b0;
      w_sof      = 1'b0;
      w_eof      = 1'b0;
    end else if (r_state != IDLE) begin
      if (!w_bit_end) begin
        w_cyc = r_cyc - 1'b1;
      end else begin
        w_cyc = CYC_LAST;
        w_sof = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        if (r_left == (LEN_W+1)'(1)) begin
          w_state    = PARITY;
          w_ser_data = r_par;
          w_eof      = 1'b1;
          w_left     = '0;
        end else begin
          w_ser_data = w_adv_bit;
          w_shift    = w_adv_shift;
          w_left     = r_left - 1'b1;
        end
`else
        w_ser_data = w_adv_bit;
        w_shift    = w_adv_shift;
        w_left     = r_left - 1'b1;
        w_eof      = r_left == (LEN_W+1)'(2);
`endif
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_left      <= '0;
      r_cyc       <= '0;
      r_ser_data  <= 1'b0;
      r_ser_val   <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_hold_data <= '0;
      r_hold_len  <= '0;
      r_hold_full <= 1'b0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_left      <= w_left;
      r_cyc       <= w_cyc;
      r_ser_data  <= w_ser_data;
      r_ser_val   <= w_ser_val;
      r_sof       <= w_sof;
      r_eof       <= w_eof;
      r_hold_full <= w_hold_full;
      r_rdy_en    <= 1'b1;
      if (w_accept && !w_from_in) begin
        r_hold_data <= data_i;
        r_hold_len  <= w_in_len;
      end
    end
  end
`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_par <= 1'b0;
    else if (w_load) r_par <= ^w_aligned;
  end
`endif
endmodule

// File: tb/tb_serializer_param.sv
// tb_serializer_param: checks two serializer configurations against a per-cycle expected-output queue.
// Instance 0: MSB first, 1 clock per bit. Instance 1: LSB first, 3 clocks per bit.
module tb_serializer_param;
`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  typedef struct packed {logic d; logic sof; logic eof; logic last;} ent_t;
  logic       clk, rst_ni, up;
  logic [7:0] din [2];
  logic [3:0] lin [2];
  logic [1:0] vin, rdy, sdat, sval, sof, eof, busy;
  ent_t       q [2][$];
  int         pend [2];
  logic [31:0] obs [2];
  int         vcnt [2];
  int         n_chk, n_fail;
  serializer_param #(.DATA_W(8), .BIT_CYCLES(1), .MSB_FIRST(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .data_i(din[0]), .len_i(lin[0]), .data_val_i(vin[0]),
    .data_rdy_o(rdy[0]), .ser_data_o(sdat[0]), .ser_val_o(sval[0]), .sof_o(sof[0]),
    .eof_o(eof[0]), .busy_o(busy[0]));
  serializer_param #(.DATA_W(8), .BIT_CYCLES(3), .MSB_FIRST(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .data_i(din[1]), .len_i(lin[1]), .data_val_i(vin[1]),
    .data_rdy_o(rdy[1]), .ser_data_o(sdat[1]), .ser_val_o(sval[1]), .sof_o(sof[1]),
    .eof_o(eof[1]), .busy_o(busy[1]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Expected output stream for one accepted word: each bit held for the instance's bit period.
  function automatic void push(input int u, input logic [7:0] d, input logic [3:0] l);
    int   n, bc;
    logic p, b;
    ent_t e;
    n  = (l == 0 || l > 8) ? 8 : int'(l);
    bc = (u == 0) ? 1 : 3;
    p  = 1'b0;
    for (int k = 0; k < n + PAR; k++) begin
      if (k == n) b = p;
      else b = (u == 0) ? d[n-1-k] : d[k];
      if (k < n) p = p ^ b;
      for (int c = 0; c < bc; c++) begin
        e.d    = b;
        e.sof  = k == 0;
        e.eof  = k == n + PAR - 1;
        e.last = e.eof && c == bc - 1;
        q[u].push_back(e);
      end
    end
  endfunction
  always @(posedge clk or negedge rst_ni) up <= rst_ni;
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      ent_t e;
      logic ev;
      if (!rst_ni) begin
        q[u].delete();
        pend[u] = 0;
      end
      ev = q[u].size() != 0;
      e  = ev ? q[u][0] : '0;
      chk($sformatf("u%0d_ser_val", u), 32'(sval[u]), 32'(ev));
      chk($sformatf("u%0d_ser_data", u), 32'(sdat[u]), 32'(e.d));
      chk($sformatf("u%0d_sof", u), 32'(sof[u]), 32'(e.sof));
      chk($sformatf("u%0d_eof", u), 32'(eof[u]), 32'(e.eof));
      chk($sformatf("u%0d_rdy", u), 32'(rdy[u]), 32'(up && pend[u] <= 1));
      chk($sformatf("u%0d_busy", u), 32'(busy[u]), 32'(pend[u] != 0));
      if (sval[u]) begin
        obs[u] = {obs[u][30:0], sdat[u]};
        vcnt[u]++;
      end
      if (ev) begin
        void'(q[u].pop_front());
        if (e.last) pend[u]--;
      end
      if (rst_ni && vin[u] && rdy[u]) begin
        push(u, din[u], lin[u]);
        pend[u]++;
      end
    end
  end
  task automatic send(input int u, input logic [7:0] d, input logic [3:0] l);
    int t;
    din[u] = d;
    lin[u] = l;
    vin[u] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rdy[u] && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("u%0d_send_timeout", u), 32'(rdy[u]), 32'd1);
    @(posedge clk);
    #1 vin[u] = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", 32'(t < 3000), 32'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    obs[0] = '0; obs[1] = '0; vcnt[0] = 0; vcnt[1] = 0;
  endtask
  initial begin
    n_chk = 0; n_fail = 0;
    rst_ni = 1'b0; vin = '0;
    din[0] = '0; din[1] = '0; lin[0] = '0; lin[1] = '0;
    pend[0] = 0; pend[1] = 0;
    clr();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1 clr();
    send(0, 8'hA5, 4'd8);
    drain();
    chk("a5_bits", PAR ? obs[0][8:0] : obs[0][7:0], PAR ? 9'h14A : 9'h0A5);
    chk("a5_len", 32'(vcnt[0]), 32'(8 + PAR));
    clr();
    send(0, 8'hF0, 4'd4);
    send(0, 8'h03, 4'd2);
    drain();
    chk("b2b_bits", obs[0][7:0], PAR ? 8'b00000110 : 8'b00000011);
    chk("b2b_len", 32'(vcnt[0]), 32'(6 + 2 * PAR));
    clr();
    send(1, 8'h81, 4'd0);
    drain();
    chk("lsb_clamp_bits", obs[1][26:0], PAR ? 27'h7000038 : 27'h0E00007);
    chk("lsb_clamp_len", 32'(vcnt[1]), 32'(24 + 3 * PAR));
`ifdef SERIALIZER_PARITY_EN
    clr();
    send(0, 8'h07, 4'd3);
    drain();
    chk("parity_bits", obs[0][3:0], 4'b1111);
    chk("parity_len", 32'(vcnt[0]), 32'd4);
`endif
    send(0, 8'hC3, 4'd8);
    send(0, 8'h5A, 4'd8);
    @(posedge clk);
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_ser_val", 32'(sval[0]), 32'd0);
    chk("arst_ser_data", 32'(sdat[0]), 32'd0);
    chk("arst_sof", 32'(sof[0]), 32'd0);
    chk("arst_eof", 32'(eof[0]), 32'd0);
    chk("arst_busy", 32'(busy[0]), 32'd0);
    chk("arst_rdy", 32'(rdy[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    clr();
    repeat (20) @(posedge clk);
    #1 chk("arst_no_residual", 32'(vcnt[0]), 32'd0);
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int g;
          send(0, 8'($urandom), 4'($urandom_range(0, 15)));
          g = $urandom_range(0, 3);
          if (g > 1) begin
            repeat (g * 3) @(posedge clk);
            #1;
          end
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          int g;
          send(1, 8'($urandom), 4'($urandom_range(0, 15)));
          g = $urandom_range(0, 3);
          if (g > 1) begin
            repeat (g * 10) @(posedge clk);
            #1;
          end
        end
      end
    join
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
